// File: rtl/instr_fetch_decode.sv
// Instruction fetch and decode front end: fetches one 32-bit word per
// fetch_start, latches it with its address and decodes fields/immediate.
//
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   fetch_start, pc_load     fetch request / PC load (pc_in, word aligned)
//   mem_req, mem_addr        instruction memory request, address = PC
//   mem_ack, mem_rdata       memory data valid, instruction word
//   instr, pc_out            latched instruction and its address
//   op_code .. rd, imm       combinational decode of instr
//   instr_valid, busy        new-instruction pulse, fetch in progress
//   fetch_err                sticky fetch timeout flag
//
// Build option: define FETCH_TIMEOUT_EN to add the fetch watchdog and the
// ERR state. Without it a fetch waits for mem_ack forever and fetch_err
// is tied low.

module instr_fetch_decode #(
    parameter logic [63:0] RESET_PC       = 64'h0,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        fetch_start,
    input  logic        pc_load,
    input  logic [63:0] pc_in,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic [6:0]  op_code,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [63:0] imm,
    output logic [63:0] pc_out,
    output logic        instr_valid,
    output logic        busy,
    output logic        fetch_err
);

`ifdef FETCH_TIMEOUT_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;
`endif

    state_t      state;
    state_t      state_nxt;
    logic [63:0] pc;

    // Control strobes produced by the FSM for the datapath registers.
    logic        pc_ld;
    logic        ack_take;
    logic        err_set;
    logic        err_clr;

`ifdef FETCH_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd;
    logic            wd_expire;

    // The count already holds the number of ack-less REQ cycles before
    // this one, so this cycle is the last allowed one.
    assign wd_expire = (wd == WD_LAST);
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        mem_req     = 1'b0;
        busy        = 1'b0;
        instr_valid = 1'b0;
        pc_ld       = 1'b0;
        ack_take    = 1'b0;
        err_set     = 1'b0;
        err_clr     = 1'b0;

        unique case (state)
            IDLE: begin
                pc_ld = pc_load;
                if (fetch_start) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                busy    = 1'b1;
                if (mem_ack) begin
                    // An ack in the watchdog's last cycle still completes.
                    ack_take  = 1'b1;
                    state_nxt = DONE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (wd_expire) begin
                    err_set   = 1'b1;
                    state_nxt = ERR;
                end
`endif
            end
            DONE: begin
                busy        = 1'b1;
                instr_valid = 1'b1;
                state_nxt   = IDLE;
            end
`ifdef FETCH_TIMEOUT_EN
            ERR: begin
                pc_ld = pc_load;
                if (fetch_start) begin
                    err_clr   = 1'b1;
                    state_nxt = REQ;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Program counter and instruction latch
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc     <= RESET_PC;
            instr  <= 32'h0;
            pc_out <= 64'h0;
        end else begin
            if (pc_ld) begin
                // Loaded targets are forced word aligned.
                pc <= pc_in & ~64'h3;
            end else if (ack_take) begin
                pc <= pc + 64'd4;
            end
            if (ack_take) begin
                instr  <= mem_rdata;
                pc_out <= pc;
            end
        end
    end

    assign mem_addr = pc;

    // ------------------------------------------------------------------
    // Fetch watchdog
    // ------------------------------------------------------------------
`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wd        <= '0;
            fetch_err <= 1'b0;
        end else begin
            // Held at zero outside REQ, so every REQ entry starts fresh.
            if (state != REQ) begin
                wd <= '0;
            end else if (!mem_ack) begin
                wd <= wd + WD_W'(1);
            end
            if (err_set) begin
                fetch_err <= 1'b1;
            end else if (err_clr) begin
                fetch_err <= 1'b0;
            end
        end
    end
`else
    assign fetch_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign op_code = instr[6:0];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];
    assign rs1     = instr[19:15];
    assign rs2     = instr[24:20];
    assign rd      = instr[11:7];

    logic [63:0] imm_i;
    logic [63:0] imm_s;
    logic [63:0] imm_b;
    logic [63:0] imm_u;
    logic [63:0] imm_j;

    assign imm_i = {{52{instr[31]}}, instr[31:20]};
    assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{52{instr[31]}}, instr[7], instr[30:25],
                    instr[11:8], 1'b0};
    assign imm_u = {{32{instr[31]}}, instr[31:12], 12'h0};
    assign imm_j = {{44{instr[31]}}, instr[19:12], instr[20],
                    instr[30:21], 1'b0};

    always_comb begin
        imm = 64'h0;
        unique case (op_code)
            7'b0010011,
            7'b0000011,
            7'b1110011: imm = imm_i;
            7'b0100011: imm = imm_s;
            7'b1100011: imm = imm_b;
            // This opcode uses the branch layout only when funct3 is 001.
            7'b1100111: imm = (funct3 == 3'b001) ? imm_b : imm_i;
            7'b0110111: imm = imm_u;
            7'b1101111: imm = imm_j;
            default:    imm = 64'h0;
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_decode.sv
module tb_instr_fetch_decode;

    localparam logic [63:0] RST_PC = 64'h0;

    logic        CLK = 1'b0;
    logic        RST;
    logic        fetch_start;
    logic        pc_load;
    logic [63:0] pc_in;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [6:0]  op_code;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic [63:0] pc_out;
    logic        instr_valid;
    logic        busy;
    logic        fetch_err;

    instr_fetch_decode #(
        .RESET_PC      (RST_PC),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .fetch_start(fetch_start),
        .pc_load    (pc_load),
        .pc_in      (pc_in),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .instr      (instr),
        .op_code    (op_code),
        .funct3     (funct3),
        .funct7     (funct7),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .imm        (imm),
        .pc_out     (pc_out),
        .instr_valid(instr_valid),
        .busy       (busy),
        .fetch_err  (fetch_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] w;
        logic [63:0] a;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          tests  = 0;
    int          fails  = 0;
    int          pulses = 0;
    int          pushes = 0;
    logic [31:0] hold_instr = 32'h0;
    logic [63:0] hold_pc    = 64'h0;
    logic [63:0] mpc;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Sign-extend the low 'bits' bits of v.
    function automatic logic [63:0] sext(input logic [63:0] v,
                                         input int bits);
        logic [63:0] m;
        logic [63:0] t;
        m = 64'd1 << (bits - 1);
        t = v & ((64'd1 << bits) - 64'd1);
        return (t ^ m) - m;
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] w);
        logic [63:0] i_v, s_v, b_v, u_v, j_v;
        i_v = sext(64'(w >> 20), 12);
        s_v = sext((64'(w >> 25) << 5) + 64'(w[11:7]), 12);
        b_v = sext((64'(w[31]) << 12) + (64'(w[7]) << 11)
                 + (64'(w[30:25]) << 5) + (64'(w[11:8]) << 1), 13);
        u_v = sext(64'(w) & 64'hFFFF_F000, 32);
        j_v = sext((64'(w[31]) << 20) + (64'(w[19:12]) << 12)
                 + (64'(w[20]) << 11) + (64'(w[30:21]) << 1), 21);
        case (w[6:0])
            7'h13, 7'h03, 7'h73: return i_v;
            7'h23:               return s_v;
            7'h63:               return b_v;
            7'h67:               return (w[14:12] == 3'd1) ? b_v : i_v;
            7'h37:               return u_v;
            7'h6F:               return j_v;
            default:             return 64'h0;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [10];
        logic [31:0] w;
        ops = '{7'h13, 7'h03, 7'h73, 7'h23, 7'h63,
                7'h67, 7'h37, 7'h6F, 7'h33, 7'h00};
        w = $urandom;
        if ($urandom_range(0, 9) != 0) begin
            w[6:0] = ops[$urandom_range(0, 9)];
        end
        return w;
    endfunction

    // Monitor: pops the scoreboard on every instr_valid pulse and checks
    // that instr/pc_out hold between pulses.
    always @(negedge CLK) begin
        if (RST) begin
            hold_instr = 32'h0;
            hold_pc    = 64'h0;
        end else if (instr_valid) begin
            pulses++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got instr %h expected none",
                         instr);
            end else begin
                mon_e = sb.pop_front();
                chk("instr", 64'(instr), 64'(mon_e.w));
                chk("pc_out", pc_out, mon_e.a);
                chk("imm", imm, ref_imm(mon_e.w));
                chk("op_code", 64'(op_code), 64'(mon_e.w[6:0]));
                chk("funct3", 64'(funct3), 64'(mon_e.w[14:12]));
                chk("funct7", 64'(funct7), 64'(mon_e.w[31:25]));
                chk("rs1", 64'(rs1), 64'(mon_e.w[19:15]));
                chk("rs2", 64'(rs2), 64'(mon_e.w[24:20]));
                chk("rd", 64'(rd), 64'(mon_e.w[11:7]));
                hold_instr = mon_e.w;
                hold_pc    = mon_e.a;
            end
        end else begin
            chk("instr_hold", 64'(instr), 64'(hold_instr));
            chk("pc_out_hold", pc_out, hold_pc);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One complete fetch; noise drives ignored requests/acks while busy.
    task automatic do_fetch(input bit ld, input logic [63:0] ldv,
                            input int w, input logic [31:0] d,
                            input bit noise);
        logic [63:0] ea;
        if (ld) mpc = ldv & ~64'h3;
        ea = mpc;
        fetch_start = 1'b1;
        pc_load     = ld;
        pc_in       = ldv;
        tick();
        fetch_start = 1'b0;
        pc_load     = 1'b0;
        chk("req_mem_req", 64'(mem_req), 64'd1);
        chk("req_addr", mem_addr, ea);
        chk("req_busy", 64'(busy), 64'd1);
        chk("req_err", 64'(fetch_err), 64'd0);
        for (int i = 0; i < w; i++) begin
            if (noise) begin
                fetch_start = 1'($urandom_range(0, 1));
                pc_load     = 1'($urandom_range(0, 1));
                pc_in       = {$urandom, $urandom};
            end
            tick();
            fetch_start = 1'b0;
            pc_load     = 1'b0;
            chk("wait_mem_req", 64'(mem_req), 64'd1);
            chk("wait_addr", mem_addr, ea);
        end
        mem_ack   = 1'b1;
        mem_rdata = d;
        sb.push_back('{d, ea});
        pushes++;
        mpc = ea + 64'd4;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        chk("done_valid", 64'(instr_valid), 64'd1);
        chk("done_busy", 64'(busy), 64'd1);
        chk("done_mem_req", 64'(mem_req), 64'd0);
        if (noise) begin
            fetch_start = 1'($urandom_range(0, 1));
            mem_ack     = 1'($urandom_range(0, 1));
            pc_load     = 1'($urandom_range(0, 1));
            pc_in       = {$urandom, $urandom};
        end
        tick();
        fetch_start = 1'b0;
        pc_load     = 1'b0;
        mem_ack     = 1'b0;
        chk("idle_valid", 64'(instr_valid), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_mem_req", 64'(mem_req), 64'd0);
        chk("next_pc", mem_addr, mpc);
    endtask

    // Idle cycles with stray acks and random data that must be ignored.
    task automatic idle_noise(input int n);
        for (int i = 0; i < n; i++) begin
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            tick();
            chk("stray_busy", 64'(busy), 64'd0);
            chk("stray_mem_req", 64'(mem_req), 64'd0);
        end
        mem_ack = 1'b0;
    endtask

    task automatic reset_mid_req();
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        chk("pre_rst_mem_req", 64'(mem_req), 64'd1);
        RST = 1'b1;
        #1;
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_pc_out", pc_out, 64'd0);
        chk("rst_addr", mem_addr, RST_PC);
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
        tick();
        RST = 1'b0;
        tick();
        mem_ack = 1'b0;
        chk("late_ack_valid", 64'(instr_valid), 64'd0);
        chk("late_ack_busy", 64'(busy), 64'd0);
        chk("late_ack_addr", mem_addr, RST_PC);
        mpc = RST_PC;
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic timeout_run(input bit ld, input logic [63:0] ldv);
        if (ld) mpc = ldv & ~64'h3;
        fetch_start = 1'b1;
        pc_load     = ld;
        pc_in       = ldv;
        tick();
        fetch_start = 1'b0;
        pc_load     = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("to_mem_req", 64'(mem_req), 64'd1);
            chk("to_err_low", 64'(fetch_err), 64'd0);
            tick();
        end
        chk("to_err", 64'(fetch_err), 64'd1);
        chk("to_mem_req_off", 64'(mem_req), 64'd0);
        chk("to_busy", 64'(busy), 64'd0);
        chk("to_pc_kept", mem_addr, mpc);
        idle_noise(3);
        chk("to_err_sticky", 64'(fetch_err), 64'd1);
    endtask
`endif

    initial begin
        RST         = 1'b1;
        fetch_start = 1'b0;
        pc_load     = 1'b0;
        pc_in       = 64'h0;
        mem_ack     = 1'b0;
        mem_rdata   = 32'h0;
        mpc         = RST_PC;
        repeat (3) tick();
        chk("reset_mem_req", 64'(mem_req), 64'd0);
        chk("reset_addr", mem_addr, RST_PC);
        chk("reset_instr", 64'(instr), 64'd0);
        chk("reset_pc_out", pc_out, 64'd0);
        chk("reset_valid", 64'(instr_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_err", 64'(fetch_err), 64'd0);
        RST = 1'b0;
        tick();

        do_fetch(1'b0, 64'h0, 0, 32'h00A30293, 1'b0);
        chk("addi_imm", imm, 64'd10);
        chk("addi_rd", 64'(rd), 64'd5);
        chk("addi_pc_out", pc_out, 64'h0);
        chk("addi_next_pc", mem_addr, 64'h4);

        do_fetch(1'b1, 64'h103, 3, 32'hFE000EE3, 1'b0);
        chk("beq_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("beq_pc_out", pc_out, 64'h100);
        chk("beq_next_pc", mem_addr, 64'h104);

        idle_noise(4);
        do_fetch(1'b0, 64'h0, 2, rand_instr(), 1'b1);
        idle_noise(3);

        do_fetch(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1, rand_instr(), 1'b0);
        chk("wrap_pc", mem_addr, 64'h0);

        reset_mid_req();
        do_fetch(1'b0, 64'h0, 1, rand_instr(), 1'b0);

        for (int n = 0; n < 60; n++) begin
            do_fetch(($urandom_range(0, 3) == 0), {$urandom, $urandom},
                     $urandom_range(0, 5), rand_instr(),
                     1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle_noise($urandom_range(1, 3));
        end

`ifdef FETCH_TIMEOUT_EN
        timeout_run(1'b0, 64'h0);
        do_fetch(1'b0, 64'h0, 2, rand_instr(), 1'b0);
        chk("to_err_cleared", 64'(fetch_err), 64'd0);
        do_fetch(1'b0, 64'h0, 15, rand_instr(), 1'b0);
        chk("ack_at_limit_err", 64'(fetch_err), 64'd0);
        timeout_run(1'b0, 64'h0);
        do_fetch(1'b1, 64'h2468, 0, rand_instr(), 1'b0);
        chk("err_load_err", 64'(fetch_err), 64'd0);
`endif

        repeat (3) tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("pulse_count", 64'(pulses), 64'(pushes));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
